// File: rtl/wb_unit.sv
// Writeback unit: retires ALU, PC+4 and formatted load results to the
// register-file write port, holding loads until the read data arrives or times out.
//
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   issue_valid/issue_ready    instruction handshake from the controller
//   sel_wb, rd_addr, funct3    result source, destination, load type
//   alu_result, pc             ALU result / load address, issuing PC
//   dmem_rvalid, dmem_rdata    data-memory read response
//   rd_we, rd_waddr, rd_wdata  register-file write port
//   busy, timeout_err          waiting for a load, sticky load-timeout flag
module wb_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        issue_valid,
  output logic        issue_ready,
  input  logic [1:0]  sel_wb,
  input  logic [4:0]  rd_addr,
  input  logic [2:0]  funct3,
  input  logic [31:0] alu_result,
  input  logic [31:0] pc,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic        rd_we,
  output logic [4:0]  rd_waddr,
  output logic [31:0] rd_wdata,
  output logic        busy,
  output logic        timeout_err
);

  localparam int unsigned CW =
    (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic {
    IDLE,
    WAIT_MEM
  } state_e;

  state_e        state_q;
  logic [4:0]    rd_q;
  logic [2:0]    f3_q;
  logic [1:0]    off_q;
  logic [CW-1:0] cnt_q;
  logic          we_q;
  logic [4:0]    waddr_q;
  logic [31:0]   wdata_q;
  logic          terr_q;

  logic [31:0]   shifted;
  logic [7:0]    ld_byte;
  logic [15:0]   ld_half;
  logic [31:0]   ld_data_d;

  // Lane extraction from the aligned word, then sign/zero extension.
  always_comb begin
    shifted   = dmem_rdata >> {off_q, 3'b000};
    ld_byte   = shifted[7:0];
    ld_half   = off_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    ld_data_d = 32'd0;
    case (f3_q)
      3'b000:  ld_data_d = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_data_d = {{16{ld_half[15]}}, ld_half};
      3'b010:  ld_data_d = dmem_rdata;
      3'b100:  ld_data_d = {24'd0, ld_byte};
      3'b101:  ld_data_d = {16'd0, ld_half};
      default: ld_data_d = 32'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rd_q    <= 5'd0;
      f3_q    <= 3'd0;
      off_q   <= 2'd0;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      waddr_q <= 5'd0;
      wdata_q <= 32'd0;
      terr_q  <= 1'b0;
    end else begin
      we_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (issue_valid) begin
            unique case (sel_wb)
              2'b00: begin
                we_q    <= (rd_addr != 5'd0);
                waddr_q <= rd_addr;
                wdata_q <= alu_result;
              end
              2'b10: begin
                we_q    <= (rd_addr != 5'd0);
                waddr_q <= rd_addr;
                wdata_q <= pc + 32'd4;
              end
              2'b01: begin
                rd_q    <= rd_addr;
                f3_q    <= funct3;
                off_q   <= alu_result[1:0];
                cnt_q   <= '0;
                state_q <= WAIT_MEM;
              end
              default: ;
            endcase
          end
        end
        WAIT_MEM: begin
          // A response in the final wait cycle still wins over the timeout.
          if (dmem_rvalid) begin
            we_q    <= (rd_q != 5'd0);
            waddr_q <= rd_q;
            wdata_q <= ld_data_d;
            state_q <= IDLE;
          end else if (cnt_q == CNT_LAST) begin
            terr_q  <= 1'b1;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign issue_ready = (state_q == IDLE);
  assign busy        = (state_q == WAIT_MEM);
  assign rd_we       = we_q;
  assign rd_waddr    = waddr_q;
  assign rd_wdata    = wdata_q;
  assign timeout_err = terr_q;

endmodule

// File: tb/tb_wb_unit.sv
// Directed bench for wb_unit: reset, ALU/PC+4 retire, load formatting,
// load wait/timeout handling, stray responses and reset during a load.
module tb_wb_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        issue_valid;
  logic        issue_ready;
  logic [1:0]  sel_wb;
  logic [4:0]  rd_addr;
  logic [2:0]  funct3;
  logic [31:0] alu_result;
  logic [31:0] pc;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic        rd_we;
  logic [4:0]  rd_waddr;
  logic [31:0] rd_wdata;
  logic        busy;
  logic        timeout_err;

  int checks = 0;
  int failures = 0;

  wb_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .sel_wb(sel_wb), .rd_addr(rd_addr), .funct3(funct3),
    .alu_result(alu_result), .pc(pc),
    .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .rd_we(rd_we), .rd_waddr(rd_waddr), .rd_wdata(rd_wdata),
    .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_issue(input logic [1:0] s, input logic [4:0] rd,
                             input logic [2:0] f3, input logic [31:0] alu,
                             input logic [31:0] p);
    issue_valid = 1'b1;
    sel_wb = s;
    rd_addr = rd;
    funct3 = f3;
    alu_result = alu;
    pc = p;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    issue_valid = 1'b0;
    sel_wb = 2'b00;
    rd_addr = 5'd0;
    funct3 = 3'd0;
    alu_result = 32'd0;
    pc = 32'd0;
    dmem_rvalid = 1'b0;
    dmem_rdata = 32'd0;
    tick();
    checks++;
    if (issue_ready !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_during ready=%b busy=%b want 1 0", issue_ready, busy);
    end
    tick();
    rst = 1'b0;
    tick();
    checks++;
    if ({rd_we, rd_waddr, rd_wdata, timeout_err, issue_ready, busy}
        !== {1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL reset_vals we=%b wa=%0d wd=%h te=%b rdy=%b busy=%b",
               rd_we, rd_waddr, rd_wdata, timeout_err, issue_ready, busy);
    end
  endtask

  task automatic test_alu();
    drive_issue(2'b00, 5'd5, 3'd0, 32'h1234_5678, 32'd0);
    tick();
    issue_valid = 1'b0;
    checks++;
    if ({rd_we, rd_waddr, rd_wdata} !== {1'b1, 5'd5, 32'h1234_5678}) begin
      failures++;
      $display("FAIL alu_write we=%b wa=%0d wd=%h want 1 5 12345678",
               rd_we, rd_waddr, rd_wdata);
    end
    tick();
    checks++;
    if (rd_we !== 1'b0) begin
      failures++;
      $display("FAIL alu_we_drop we=%b want 0", rd_we);
    end
  endtask

  task automatic test_pc4();
    drive_issue(2'b10, 5'd1, 3'd0, 32'hDEAD_BEEF, 32'hFFFF_FFFC);
    tick();
    issue_valid = 1'b0;
    checks++;
    if ({rd_we, rd_waddr, rd_wdata} !== {1'b1, 5'd1, 32'h0}) begin
      failures++;
      $display("FAIL pc4_wrap we=%b wa=%0d wd=%h want 1 1 0",
               rd_we, rd_waddr, rd_wdata);
    end
    drive_issue(2'b10, 5'd0, 3'd0, 32'd0, 32'hFFFF_FFFC);
    tick();
    issue_valid = 1'b0;
    checks++;
    if (rd_we !== 1'b0) begin
      failures++;
      $display("FAIL x0_suppress we=%b want 0", rd_we);
    end
    drive_issue(2'b11, 5'd4, 3'd0, 32'h55, 32'd0);
    tick();
    issue_valid = 1'b0;
    checks++;
    if (rd_we !== 1'b0 || issue_ready !== 1'b1) begin
      failures++;
      $display("FAIL sel11 we=%b rdy=%b want 0 1", rd_we, issue_ready);
    end
  endtask

  task automatic test_back_to_back();
    drive_issue(2'b00, 5'd10, 3'd0, 32'hAAAA_0001, 32'd0);
    tick();
    drive_issue(2'b10, 5'd11, 3'd0, 32'd0, 32'h0000_1000);
    checks++;
    if ({rd_we, rd_waddr, rd_wdata} !== {1'b1, 5'd10, 32'hAAAA_0001}) begin
      failures++;
      $display("FAIL b2b_first we=%b wa=%0d wd=%h", rd_we, rd_waddr, rd_wdata);
    end
    tick();
    issue_valid = 1'b0;
    checks++;
    if ({rd_we, rd_waddr, rd_wdata} !== {1'b1, 5'd11, 32'h0000_1004}) begin
      failures++;
      $display("FAIL b2b_second we=%b wa=%0d wd=%h", rd_we, rd_waddr, rd_wdata);
    end
  endtask

  task automatic test_load_fmt();
    logic [2:0]  f3v [6] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010, 3'b011};
    logic [1:0]  offv[6] = '{2'd3, 2'd2, 2'd2, 2'd0, 2'd1, 2'd0};
    logic [31:0] expv[6] = '{32'hFFFF_FF80, 32'h0000_00FF, 32'hFFFF_80FF,
                            32'h0000_7F01, 32'h80FF_7F01, 32'h0};
    for (int i = 0; i < 6; i++) begin
      drive_issue(2'b01, 5'd3, f3v[i], {30'h400, offv[i]}, 32'd0);
      tick();
      issue_valid = 1'b0;
      checks++;
      if (busy !== 1'b1 || issue_ready !== 1'b0) begin
        failures++;
        $display("FAIL ld_wait_%0d busy=%b rdy=%b want 1 0", i, busy, issue_ready);
      end
      dmem_rvalid = 1'b1;
      dmem_rdata = 32'h80FF_7F01;
      tick();
      dmem_rvalid = 1'b0;
      checks++;
      if ({rd_we, rd_waddr, rd_wdata, busy} !== {1'b1, 5'd3, expv[i], 1'b0}) begin
        failures++;
        $display("FAIL ld_fmt_%0d we=%b wa=%0d wd=%h busy=%b want wd=%h",
                 i, rd_we, rd_waddr, rd_wdata, busy, expv[i]);
      end
    end
  endtask

  task automatic test_load_wait();
    drive_issue(2'b01, 5'd7, 3'b010, 32'h0000_2000, 32'd0);
    tick();
    issue_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (busy !== 1'b1 || issue_ready !== 1'b0 || rd_we !== 1'b0) begin
        failures++;
        $display("FAIL lw_waiting_%0d busy=%b rdy=%b we=%b want 1 0 0",
                 i, busy, issue_ready, rd_we);
      end
    end
    dmem_rvalid = 1'b1;
    dmem_rdata = 32'hCAFE_F00D;
    tick();
    dmem_rvalid = 1'b0;
    checks++;
    if ({rd_we, rd_waddr, rd_wdata, issue_ready}
        !== {1'b1, 5'd7, 32'hCAFE_F00D, 1'b1}) begin
      failures++;
      $display("FAIL lw_retire we=%b wa=%0d wd=%h rdy=%b",
               rd_we, rd_waddr, rd_wdata, issue_ready);
    end
    drive_issue(2'b00, 5'd8, 3'd0, 32'h0000_0042, 32'd0);
    tick();
    issue_valid = 1'b0;
    checks++;
    if ({rd_we, rd_waddr, rd_wdata} !== {1'b1, 5'd8, 32'h42}) begin
      failures++;
      $display("FAIL lw_then_alu we=%b wa=%0d wd=%h", rd_we, rd_waddr, rd_wdata);
    end
  endtask

  task automatic test_timeout();
    drive_issue(2'b01, 5'd9, 3'b010, 32'h0, 32'd0);
    tick();
    issue_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (busy !== 1'b1 || rd_we !== 1'b0 || timeout_err !== 1'b0) begin
        failures++;
        $display("FAIL to_wait_%0d busy=%b we=%b te=%b want 1 0 0",
                 i, busy, rd_we, timeout_err);
      end
    end
    tick();
    checks++;
    if (busy !== 1'b0 || rd_we !== 1'b0 || timeout_err !== 1'b1) begin
      failures++;
      $display("FAIL to_fire busy=%b we=%b te=%b want 0 0 1",
               busy, rd_we, timeout_err);
    end
    drive_issue(2'b00, 5'd2, 3'd0, 32'h77, 32'd0);
    tick();
    issue_valid = 1'b0;
    tick();
    checks++;
    if (timeout_err !== 1'b1) begin
      failures++;
      $display("FAIL to_sticky te=%b want 1", timeout_err);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (timeout_err !== 1'b0) begin
      failures++;
      $display("FAIL to_clear te=%b want 0", timeout_err);
    end
    drive_issue(2'b01, 5'd12, 3'b010, 32'h0, 32'd0);
    tick();
    issue_valid = 1'b0;
    tick();
    tick();
    tick();
    dmem_rvalid = 1'b1;
    dmem_rdata = 32'h0BAD_CAFE;
    tick();
    dmem_rvalid = 1'b0;
    checks++;
    if ({rd_we, rd_waddr, rd_wdata, timeout_err, busy}
        !== {1'b1, 5'd12, 32'h0BAD_CAFE, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL to_last_cycle we=%b wa=%0d wd=%h te=%b busy=%b",
               rd_we, rd_waddr, rd_wdata, timeout_err, busy);
    end
  endtask

  task automatic test_stray();
    dmem_rvalid = 1'b1;
    dmem_rdata = 32'h1111_1111;
    tick();
    dmem_rvalid = 1'b0;
    checks++;
    if (rd_we !== 1'b0 || busy !== 1'b0 || issue_ready !== 1'b1) begin
      failures++;
      $display("FAIL stray_idle we=%b busy=%b rdy=%b", rd_we, busy, issue_ready);
    end
    drive_issue(2'b01, 5'd6, 3'b010, 32'h0, 32'd0);
    tick();
    issue_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (busy !== 1'b0 || issue_ready !== 1'b1 || rd_we !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid_wait busy=%b rdy=%b we=%b", busy, issue_ready, rd_we);
    end
    dmem_rvalid = 1'b1;
    dmem_rdata = 32'h2222_2222;
    tick();
    dmem_rvalid = 1'b0;
    checks++;
    if (rd_we !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL late_rvalid we=%b busy=%b want 0 0", rd_we, busy);
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_pc4();
    test_back_to_back();
    test_load_fmt();
    test_load_wait();
    test_timeout();
    test_stray();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wb_unit.md
# wb_unit

Writeback unit: the return path from execute to the register file. Each cycle it accepts one completed instruction from the controller, selects the ALU result, a formatted data-memory load, or PC+4, and drives the single register-file write port. Loads are held in a wait state until the data-memory read response arrives or a timeout expires. Non-load results retire with one-cycle latency at full throughput.

## Interface
- TIMEOUT_CYCLES, 255, maximum cycles spent waiting for `dmem_rvalid` after a load issue; must be ≥1.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- issue_valid  in  1  controller presents an instruction for writeback.
- issue_ready  out  1  unit can accept; transfer occurs when `issue_valid & issue_ready`.
- sel_wb  in  2  source: 00 ALU, 01 MEM (load), 10 PC+4, 11 reserved.
- rd_addr  in  5  destination register.
- funct3  in  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- alu_result  in  32  ALU result; for loads, the byte address (bits [1:0] select the lane).
- pc  in  32  PC of the issuing instruction.
- dmem_rvalid  in  1  one-cycle pulse: read data valid.
- dmem_rdata  in  32  aligned 32-bit word from data memory.
- rd_we  out  1  register-file write enable, one cycle per write.
- rd_waddr  out  5  register-file write address.
- rd_wdata  out  32  register-file write data.
- busy  out  1  high while in WAIT_MEM.
- timeout_err  out  1  sticky: a load timed out. Cleared only by `rst`.

## Operation
- States: IDLE and WAIT_MEM. `issue_ready = (state == IDLE)`. `busy = (state == WAIT_MEM)`.
- IDLE, on accepted issue:
  - sel 00: register `alu_result`.
  - sel 10: register `pc + 4`, truncated mod 2^32.
  - For sel 00 and sel 10, `rd_we` goes to 1 next cycle, with `rd_waddr = rd_addr`, and the state stays IDLE.
  - sel 11: accepted, produces no write.
  - sel 01: latch `rd_addr`, `funct3` and `alu_result[1:0]`; clear the timeout counter; go to WAIT_MEM.
- `rd_addr == 0` never asserts `rd_we`. This covers all sources, including completed loads.
- WAIT_MEM, on `dmem_rvalid`: format the data, register it, pulse `rd_we` next cycle, return to IDLE.
- Load formatting, with byte lane selected by `off = addr[1:0]`:
  - LB: sign-extend `rdata[8*off+7 : 8*off]`.
  - LBU: zero-extend the same byte.
  - LH: sign-extend halfword `addr[1]` (off[0] ignored).
  - LHU: zero-extend the same halfword.
  - LW: whole word; off ignored.
  - funct3 011/110/111: write 0.
- Timeout: the counter increments each WAIT_MEM cycle without `rvalid`. When it reaches TIMEOUT_CYCLES−1 with no `rvalid`, set `timeout_err`, return to IDLE, and perform no write.
- `rvalid` in the same cycle as the timeout: the write wins and `timeout_err` is not set.
- `dmem_rvalid` while in IDLE is ignored. No write occurs and no state changes.
- `rd_we` is low in every cycle other than the single retire cycle.

## Timing
- Reset values: state IDLE, `rd_we` 0, `rd_waddr` 0, `rd_wdata` 0, `timeout_err` 0, counter 0. Therefore `issue_ready` is 1 and `busy` is 0 during and after reset.
- Reset mid-WAIT_MEM: the pending load is dropped with no write, and a later `rvalid` is ignored.
- ALU/PC+4 latency: issue at cycle t gives `rd_we` at t+1. Back-to-back issues give back-to-back writes.
- Load latency: `rvalid` at cycle t gives `rd_we` at t+1. `issue_ready` is already 1 at t+1, so a new issue accepted at t+1 writes at t+2.
- The earliest valid `rvalid` is 1 cycle after the load is accepted. A `rvalid` is accepted in any of cycles 1..TIMEOUT_CYCLES after issue.

## Test plan
- Reset then ALU: issue sel=00, rd=5, alu=0x1234_5678 at cycle 1 → cycle 2: `rd_we`=1, waddr=5, wdata=0x1234_5678. Cycle 3: `rd_we`=0.
- PC+4 wrap plus x0 suppression: pc=0xFFFF_FFFC, sel=10, rd=1 → wdata=0x0000_0000. The same issue with rd=0 → `rd_we` stays 0.
- Load formatting with rdata=0x80FF_7F01:
  - LB off=3 → 0xFFFF_FF80.
  - LBU off=2 → 0x0000_00FF.
  - LH off=2 → 0xFFFF_80FF.
  - LHU off=0 → 0x0000_7F01.
  - LW → 0x80FF_7F01.
  - funct3=011 → 0.
- Load wait: issue LW, rd=7; `rvalid` 3 cycles later → `issue_ready`=0 and `busy`=1 while waiting, `rd_we` the cycle after `rvalid`. A new ALU issue on that same cycle writes one cycle later.
- Timeout with TIMEOUT_CYCLES=4:
  - No `rvalid` → back in IDLE after 4 wait cycles, `timeout_err`=1, no write, and the flag is held until `rst`.
  - Repeat with `rvalid` in the 4th cycle → write occurs and `timeout_err`=0.
- Stray `rvalid` in IDLE, plus reset during WAIT_MEM followed by a late `rvalid` → no writes and state remains IDLE.
